byte_mem_responder: RTL and testbench
=====================================

# byte_mem_responder

Memory-side responder for the core's 32-bit load/store/fetch requests. It serves each request from an internal byte-wide array, one byte per cycle, and returns a single response. Byte, half and word widths are supported at any alignment, little-endian, with sign or zero extension on reads. It replaces direct word access to `Ram` by the control FSM, which becomes a requester that waits on `rsp_valid`.

## Interface
- `DEPTH_BYTES`, default `'h10000`: size of the byte array; valid byte addresses are 0..DEPTH_BYTES-1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load/fetch.
- `req_width`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned`  in  1  reads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address of the least significant byte.
- `req_wdata`  in  32  store data; the low 8/16/32 bits are used.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  extended read data; 0 for writes and errors.
- `rsp_error`  out  1  qualifies `rsp_valid`: request rejected.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, the responder latches write, width, unsigned, addr and wdata, clears the byte counter `idx` and the assembly register, and checks the request.
  - Byte count n = 1/2/4 for width 0/1/2.
  - The request is an error if width==3, or if addr+n-1 >= DEPTH_BYTES. The sum is computed in 33 bits, so there is no wrap-around at 2^32.
  - Valid request goes to ACCESS. Error goes to RESPOND with the error flag set and no array access.
- ACCESS: one byte per cycle at address addr+idx.
  - Write: array[addr+idx] <= wdata[8*idx +: 8].
  - Read: assembly[8*idx +: 8] <= array[addr+idx].
  - `idx` increments each cycle. When idx==n-1 the FSM goes to RESPOND.
- RESPOND:
  - `rsp_valid`=1 for exactly this cycle.
  - `rsp_error` holds the error flag.
  - `rsp_rdata` for a read is the assembly extended from bit 8n-1 (sign or zero, per `req_unsigned`). For a write or an error it is 0.
  - Next state is IDLE.
- `req_ready`=0 in ACCESS and RESPOND. A `req_valid` asserted in those states is ignored and must be held by the requester.
- Misaligned accesses are legal. Example: a word at 0xFF covers bytes 0xFF..0x102.
- Request inputs are sampled only at acceptance. Later changes have no effect.

## Timing
- Reset (asynchronous, immediate):
  - FSM=IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0.
  - `idx`=0, assembly register=0.
- The array contents are not reset.
- Latency: accept at edge 0 → n ACCESS cycles → `rsp_valid` high in cycle n+1. Word = 5 cycles to response; byte = 2.
- An error response comes 1 cycle after acceptance.
- Next acceptance is possible in the cycle after RESPOND. Back-to-back word throughput is 1 request per 6 cycles.
- Reset mid-ACCESS:
  - Bytes already written stay written; the remaining bytes are not written.
  - No response is issued.
  - Ready is 1 right after reset deassertion.
- `rsp_rdata` and `rsp_error` are valid only while `rsp_valid`=1 and are 0 otherwise.

## Test plan
- Misaligned word store then load:
  - Stimulus: word write 0x12345678 at 0xFF, then word read at 0xFF.
  - Required: array[0xFF..0x102] = 78,56,34,12. Read returns 0x12345678 with `rsp_error`=0. `rsp_valid` comes exactly 5 cycles after each accept; `req_ready` is 0 for 5 cycles.
- Byte read extension:
  - Stimulus: byte 0x80 stored at 0x80; signed byte read, then unsigned byte read.
  - Required: signed read → 0xFFFFFF80; unsigned read → 0x00000080.
- Half store scope:
  - Stimulus: word 0xAAAAAAAA at 0x10, then half write 0xBEEF at 0x11, then word read at 0x10.
  - Required: read returns 0xAABEEFAA.
- Range and width errors:
  - Stimulus: word write at DEPTH_BYTES-2; word read at 0xFFFFFFFE; width=3 request.
  - Required: each gets `rsp_valid` 1 cycle after accept with `rsp_error`=1 and `rsp_rdata`=0. The array is unchanged.
- Reset mid-write:
  - Stimulus: assert `rst` after 2 ACCESS cycles of a word write.
  - Required: only the first 2 bytes are changed, no `rsp_valid` appears, and `req_ready`=1 immediately.
- Ignored request and latching:
  - Stimulus: hold `req_valid`=1 with changing addr during ACCESS.
  - Required: the held request is not accepted until IDLE, and the in-flight data comes from the latched address.

Source files
------------

// File: rtl/byte_mem_responder.sv
// Byte-serial memory responder: accepts one load/store request, walks it through
// an internal byte array one byte per cycle, then issues a single response strobe.
module byte_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 'h10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t         state_q, state_d;
    logic           write_q, write_d;
    logic [1:0]     width_q, width_d;
    logic           unsigned_q, unsigned_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [1:0]     idx_q, idx_d;
    logic [31:0]    asm_q, asm_d;
    logic           err_q, err_d;

    logic [7:0]     mem [DEPTH_BYTES];
    logic [AW-1:0]  cur_addr;
    logic [7:0]     mem_rd;
    logic           mem_we;
    logic [32:0]    req_end;
    logic           req_err;

    // Index of the final byte of a transfer: n-1 for n = 1/2/4.
    function automatic logic [1:0] last_idx(input logic [1:0] w);
        case (w)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] w,
                                           input logic u);
        case (w)
            2'd0:    return {{24{~u & v[7]}}, v[7:0]};
            2'd1:    return {{16{~u & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Range check in 33 bits so an address near 2^32 cannot wrap back into range.
    assign req_end  = {1'b0, req_addr} + {31'b0, last_idx(req_width)};
    assign req_err  = (req_width == 2'd3) || (req_end >= 33'(DEPTH_BYTES));

    // Only the low AW address bits are kept: any accepted request lies below DEPTH_BYTES.
    assign cur_addr = addr_q + AW'(idx_q);
    assign mem_rd   = mem[cur_addr];
    assign mem_we   = (state_q == ACCESS) && write_q;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        width_d    = width_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    width_d    = req_width;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[AW-1:0];
                    wdata_d    = req_wdata;
                    idx_d      = 2'd0;
                    asm_d      = 32'd0;
                    err_d      = req_err;
                    state_d    = req_err ? RESPOND : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    asm_d[8*idx_q +: 8] = mem_rd;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == last_idx(width_q)) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            width_q    <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            idx_q      <= 2'd0;
            asm_q      <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            width_q    <= width_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
        end
    end

    // Array contents survive reset; an async reset drops state to IDLE, which stops writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_addr] <= wdata_q[8*idx_q +: 8];
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESPOND);
    assign rsp_error = (state_q == RESPOND) && err_q;
    assign rsp_rdata = (state_q == RESPOND && !write_q && !err_q)
                       ? extend(asm_q, width_q, unsigned_q) : 32'd0;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed bench for byte_mem_responder: hand-computed vectors checked with immediate assertions.
module tb_byte_mem_responder;

    localparam int unsigned DEPTH = 'h10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_width = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int comps = 0;
    int fails = 0;

    byte_mem_responder #(.DEPTH_BYTES(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_width(req_width), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        comps++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, o, e);
        end
    endtask

    // Starts #1 after the accepting edge; returns response fields, latency and ready-low count.
    task automatic wait_rsp(output logic [31:0] rd, output logic e, output int lat, output int rl);
        lat = 1;
        rl  = 0;
        while (1) begin
            if (!req_ready) rl++;
            if (rsp_valid || lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_error;
        @(posedge clk); #1;
    endtask

    task automatic xact(input logic w, input logic [1:0] wd, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat, output int rl);
        req_valid = 1'b1; req_write = w; req_width = wd; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(rd, e, lat, rl);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, rl, seen;

        // Reset state
        #2;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_error", 32'(rsp_error), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Misaligned word store then load
        xact(1, 2, 0, 32'hFF, 32'h12345678, rd, e, lat, rl);
        chk("wr_ff_err", 32'(e), 32'd0);
        chk("wr_ff_rdata", rd, 32'd0);
        chk("wr_ff_lat", 32'(lat), 32'd5);
        chk("wr_ff_readylow", 32'(rl), 32'd5);
        chk("idle_ready", 32'(req_ready), 32'd1);
        xact(0, 2, 0, 32'hFF, 32'h0, rd, e, lat, rl);
        chk("rd_ff_data", rd, 32'h12345678);
        chk("rd_ff_err", 32'(e), 32'd0);
        chk("rd_ff_lat", 32'(lat), 32'd5);
        chk("rd_ff_readylow", 32'(rl), 32'd5);
        xact(0, 0, 1, 32'hFF, 32'h0, rd, e, lat, rl);
        chk("b_ff", rd, 32'h78);
        chk("b_ff_lat", 32'(lat), 32'd2);
        xact(0, 0, 1, 32'h100, 32'h0, rd, e, lat, rl);
        chk("b_100", rd, 32'h56);
        xact(0, 0, 1, 32'h101, 32'h0, rd, e, lat, rl);
        chk("b_101", rd, 32'h34);
        xact(0, 0, 1, 32'h102, 32'h0, rd, e, lat, rl);
        chk("b_102", rd, 32'h12);

        // Byte read extension
        xact(1, 0, 0, 32'h80, 32'h12345680, rd, e, lat, rl);
        chk("wb_80_lat", 32'(lat), 32'd2);
        xact(0, 0, 0, 32'h80, 32'h0, rd, e, lat, rl);
        chk("b_80_signed", rd, 32'hFFFFFF80);
        xact(0, 0, 1, 32'h80, 32'h0, rd, e, lat, rl);
        chk("b_80_unsigned", rd, 32'h00000080);

        // Half store scope and half reads
        xact(1, 2, 0, 32'h10, 32'hAAAAAAAA, rd, e, lat, rl);
        xact(1, 1, 0, 32'h11, 32'h1234BEEF, rd, e, lat, rl);
        chk("wh_11_lat", 32'(lat), 32'd3);
        xact(0, 2, 0, 32'h10, 32'h0, rd, e, lat, rl);
        chk("half_scope", rd, 32'hAABEEFAA);
        xact(0, 1, 0, 32'h12, 32'h0, rd, e, lat, rl);
        chk("h_12_signed", rd, 32'hFFFFAABE);
        xact(0, 1, 1, 32'h11, 32'h0, rd, e, lat, rl);
        chk("h_11_unsigned", rd, 32'h0000BEEF);
        xact(0, 1, 0, 32'h11, 32'h0, rd, e, lat, rl);
        chk("h_11_signed", rd, 32'hFFFFBEEF);

        // Range and width errors
        xact(1, 2, 0, DEPTH - 4, 32'h55667788, rd, e, lat, rl);
        xact(1, 2, 0, DEPTH - 2, 32'hDEADBEEF, rd, e, lat, rl);
        chk("err_wr_top", 32'(e), 32'd1);
        chk("err_wr_top_rdata", rd, 32'd0);
        chk("err_wr_top_lat", 32'(lat), 32'd1);
        xact(0, 2, 0, 32'hFFFFFFFE, 32'h0, rd, e, lat, rl);
        chk("err_rd_wrap", 32'(e), 32'd1);
        chk("err_rd_wrap_rdata", rd, 32'd0);
        chk("err_rd_wrap_lat", 32'(lat), 32'd1);
        xact(0, 3, 0, 32'h10, 32'h0, rd, e, lat, rl);
        chk("err_w3_rd", 32'(e), 32'd1);
        chk("err_w3_rd_rdata", rd, 32'd0);
        chk("err_w3_rd_lat", 32'(lat), 32'd1);
        xact(1, 3, 0, DEPTH - 4, 32'h01020304, rd, e, lat, rl);
        chk("err_w3_wr", 32'(e), 32'd1);
        xact(0, 1, 0, DEPTH - 1, 32'h0, rd, e, lat, rl);
        chk("err_half_last", 32'(e), 32'd1);
        xact(0, 0, 0, DEPTH - 1, 32'h0, rd, e, lat, rl);
        chk("b_last_ok_err", 32'(e), 32'd0);
        chk("b_last_ok_data", rd, 32'h00000055);
        xact(0, 2, 0, DEPTH - 4, 32'h0, rd, e, lat, rl);
        chk("top_unchanged", rd, 32'h55667788);
        xact(0, 2, 0, 32'h10, 32'h0, rd, e, lat, rl);
        chk("low_unchanged", rd, 32'hAABEEFAA);

        // Reset mid-write: two bytes land, the rest do not
        xact(1, 2, 0, 32'h200, 32'h44332211, rd, e, lat, rl);
        req_valid = 1'b1; req_write = 1'b1; req_width = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h200; req_wdata = 32'hDDCCBBAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        xact(0, 2, 0, 32'h200, 32'h0, rd, e, lat, rl);
        chk("midrst_bytes", rd, 32'h4433BBAA);

        // Held request during ACCESS is ignored; in-flight uses latched address
        req_valid = 1'b1; req_write = 1'b0; req_width = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'hFF;
        @(posedge clk); #1;
        req_addr = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h200; req_width = 2'd0; req_unsigned = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h80;
        lat = 3;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held_first_lat", 32'(lat), 32'd5);
        chk("held_first_data", rsp_rdata, 32'h12345678);
        chk("held_rsp_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("held_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("held_accepted", 32'(req_ready), 32'd0);
        wait_rsp(rd, e, lat, rl);
        chk("held_second_data", rd, 32'h00000080);
        chk("held_second_lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule
